// File: rtl/intt_addrgen_pkg.sv
// Shared types and constants for the inverse-NTT address generator.
// Derived widths, FSM state encoding and bank encoding live here.
package intt_addrgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    localparam int STAGE_W = 5;

    function automatic int addr_width(input int logn);
        return logn;
    endfunction

    function automatic int tw_width(input int logn);
        return logn - 1;
    endfunction

endpackage

// File: rtl/intt_addr_delay.sv
// Shift pipeline that carries read-side write intent to the write side,
// covering RAM read latency plus BFU latency.
module intt_addr_delay #(
    parameter int DEPTH = 5,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        q <= '0;
                    end else begin
                        q <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        q <= '0;
                    end else begin
                        q <= g_stage[gi-1].q;
                    end
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q;

endmodule

// File: rtl/intt_addrgen.sv
// Gentleman-Sande inverse-NTT address/control generator: one butterfly per
// cycle, ping-ponging between banks A and B, one bank swap per stage.
module intt_addrgen
    import intt_addrgen_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int BFU_LAT = 4,
    parameter int ADDRW   = addr_width(LOGN),
    parameter int TWW     = tw_width(LOGN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic               rd_en,
    output logic               rd_bank,
    output logic [ADDRW-1:0]   rd_addr_top,
    output logic [ADDRW-1:0]   rd_addr_bot,
    output logic [TWW-1:0]     tw_addr,
    output logic               bfu_en,
    output logic               bfu_last,
    output logic               wr_en,
    output logic               wr_bank,
    output logic [ADDRW-1:0]   wr_addr_top,
    output logic [ADDRW-1:0]   wr_addr_bot
);

    localparam int BW     = LOGN - 1;
    localparam int N_HALF = 1 << (LOGN - 1);
    localparam int CW     = $clog2(BFU_LAT + 1);
    localparam int PW     = 2 + 2 * ADDRW;

    localparam logic [BW-1:0]      B_LAST     = BW'(N_HALF - 1);
    localparam logic [CW-1:0]      CNT_LAST   = CW'(BFU_LAT);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOGN - 1);

    state_t               state_reg, state_next;
    logic [BW-1:0]        b_reg, b_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [STAGE_W-1:0]   stage_next;
    logic [PW-1:0]        pipe_in, pipe_out;

    // Top address = group*2h + offset: the group index is shifted up by one
    // extra bit, leaving bit s clear so the bottom address is top + h.
    function automatic logic [ADDRW-1:0] top_addr(input logic [BW-1:0] b,
                                                  input logic [STAGE_W-1:0] s);
        logic [ADDRW-1:0] bx;
        logic [ADDRW-1:0] mask;
        bx   = ADDRW'(b);
        mask = (ADDRW'(1) << s) - ADDRW'(1);
        return ((bx >> s) << (s + STAGE_W'(1))) | (bx & mask);
    endfunction

    function automatic logic [TWW-1:0] twiddle(input logic [BW-1:0] b,
                                               input logic [STAGE_W-1:0] s);
        logic [ADDRW-1:0] mask;
        logic [ADDRW-1:0] o;
        mask = (ADDRW'(1) << s) - ADDRW'(1);
        o    = ADDRW'(b) & mask;
        return TWW'(o << (STAGE_LAST - s));
    endfunction

    always_comb begin
        state_next = state_reg;
        stage_next = stage;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                stage_next = '0;
                b_next     = '0;
                cnt_next   = '0;
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (b_reg == B_LAST) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    b_next = b_reg + BW'(1);
                end
            end
            ST_DRAIN: begin
                // Hold off reads until the stage's last write has landed.
                if (cnt_reg == CNT_LAST) begin
                    if (stage == STAGE_LAST) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_READ;
                        stage_next = stage + STAGE_W'(1);
                        b_next     = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            b_reg       <= '0;
            cnt_reg     <= '0;
            stage       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_bank     <= BANK_A;
            rd_addr_top <= '0;
            rd_addr_bot <= '0;
            tw_addr     <= '0;
            bfu_en      <= 1'b0;
            bfu_last    <= 1'b0;
        end else begin
            state_reg <= state_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            stage     <= stage_next;
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_FINISH);
            rd_en     <= (state_next == ST_READ);
            rd_bank   <= (state_next != ST_IDLE && stage_next[0]) ? BANK_B : BANK_A;
            if (state_next == ST_READ) begin
                rd_addr_top <= top_addr(b_next, stage_next);
                rd_addr_bot <= top_addr(b_next, stage_next) + (ADDRW'(1) << stage_next);
                tw_addr     <= twiddle(b_next, stage_next);
            end else begin
                rd_addr_top <= '0;
                rd_addr_bot <= '0;
                tw_addr     <= '0;
            end
            bfu_en   <= rd_en;
            bfu_last <= rd_en && (stage == STAGE_LAST);
        end
    end

    assign pipe_in = {rd_en, rd_en ? ~rd_bank : BANK_A, rd_addr_top, rd_addr_bot};

    intt_addr_delay #(
        .DEPTH (1 + BFU_LAT),
        .W     (PW)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign {wr_en, wr_bank, wr_addr_top, wr_addr_bot} = pipe_out;

endmodule
